// File: rtl/alu_rr_arbiter_16bit_pkg.sv
// Shared constants and types for alu_rr_arbiter_16bit.
// Optional build macro: ALU_ARB_FLAG_CHECK_EN (flag consistency checker).
package alu_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // ALU opcodes
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Bit positions inside the 4-bit {carry, zero, overflow, negative} flag word
  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  // Operands latched at grant and held on the ALU inputs
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } alu_req_t;

  // Zero and negative flags must agree with the result value itself
  function automatic logic flags_consistent(input logic [15:0] r, input logic [3:0] f);
    return (f[FLG_Z] == (r == 16'd0)) && (f[FLG_N] == r[15]);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_16bit_if.sv
// Request / response / ALU-side bus of alu_rr_arbiter_16bit.
// slave: arbiter view; master: clients + ALU view.
interface alu_rr_arbiter_16bit_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][15:0] req_a;
  logic [NUM_REQ-1:0][15:0] req_b;
  logic [NUM_REQ-1:0][1:0]  req_op;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [15:0]              resp_result;
  logic [3:0]               resp_flags;

  logic [15:0]              alu_A;
  logic [15:0]              alu_B;
  logic [1:0]               alu_op;
  logic [15:0]              alu_result;
  logic [3:0]               alu_flags;

  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready, alu_result, alu_flags,
    output req_ready, resp_valid, resp_id, resp_result, resp_flags,
           alu_A, alu_B, alu_op, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready, alu_result, alu_flags,
    input  req_ready, resp_valid, resp_id, resp_result, resp_flags,
           alu_A, alu_B, alu_op, busy
  );
endinterface

// File: rtl/alu_rr_arbiter_16bit_rr_pick.sv
// Combinational round-robin selector: first set bit of vld searching
// upward from ptr with wrap. idx is only meaningful when found is high.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] vld,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               found
);
  // one extra bit so ptr+k never overflows before the wrap subtraction
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  // scan from the farthest offset down so the nearest valid wins last
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      cand = sum[ID_W-1:0];
      if (vld[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rr_arbiter_16bit.sv
// Round-robin sequencer sharing one 16-bit ALU among NUM_REQ requesters.
// IDLE grants one requester, ISSUE/WAIT cover the ALU latency, RESP holds
// the response until accepted. ID_W must equal clog2(NUM_REQ) and match
// the bus interface parameters.
// Optional build macro: ALU_ARB_FLAG_CHECK_EN adds sticky output flag_err.
module alu_rr_arbiter_16bit
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_rr_arbiter_16bit_if.slave bus
`ifdef ALU_ARB_FLAG_CHECK_EN
  ,
  output logic                  flag_err
`endif
);

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic [ID_W-1:0] gnt_id;
  logic [1:0]      wait_cnt;
  alu_req_t        lat;
  logic            capture;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .vld   (bus.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_any)
  );

  // ALU result is valid in the last WAIT cycle
  assign capture    = (state == WAIT) && (wait_cnt == 2'd0);
  assign bus.busy   = (state != IDLE);
  assign bus.alu_A  = lat.a;
  assign bus.alu_B  = lat.b;
  assign bus.alu_op = lat.op;

  // accept strobe: one-hot, only while idle, same cycle as the grant decision
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && pick_any) bus.req_ready[pick_idx] = 1'b1;
  end

  // transaction sequencer: grant, wait out ALU latency, hold response
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      gnt_id          <= '0;
      wait_cnt        <= '0;
      lat             <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= '0;
      bus.resp_result <= '0;
      bus.resp_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            lat    <= '{a: bus.req_a[pick_idx], b: bus.req_b[pick_idx], op: bus.req_op[pick_idx]};
            gnt_id <= pick_idx;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= 2'(ALU_LATENCY-1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            bus.resp_valid  <= 1'b1;
            bus.resp_id     <= gnt_id;
            bus.resp_result <= bus.alu_result;
            bus.resp_flags  <= bus.alu_flags;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            rr_ptr         <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_FLAG_CHECK_EN
  // sticky flag: ALU reported zero/negative that contradict its own result
  always_ff @(posedge clk) begin
    if (rst)
      flag_err <= 1'b0;
    else if (capture && !flags_consistent(bus.alu_result, bus.alu_flags))
      flag_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter_16bit.sv
// Directed bench for alu_rr_arbiter_16bit with a transaction-level model
// and a per-cycle compare process. Build with ALU_ARB_FLAG_CHECK_EN to
// also exercise flag_err.
module tb_alu_rr_arbiter_16bit;
  import alu_arb_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_rr_arbiter_16bit_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();
`ifdef ALU_ARB_FLAG_CHECK_EN
  logic flag_err;
`endif

  alu_rr_arbiter_16bit #(.NUM_REQ(N), .ID_W(IDW), .ALU_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ARB_FLAG_CHECK_EN
    ,
    .flag_err (flag_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference ALU: {carry, zero, overflow, negative, result}
  function automatic logic [19:0] alu_calc(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [16:0] s;
    logic [15:0] r;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      OP_SUB: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      OP_AND: r = a & b;
      default: r = a | b;
    endcase
    return {c, (r == 16'd0), v, r[15], r};
  endfunction

  // external ALU with one cycle of latency; force_bad clears the zero flag
  logic        force_bad = 1'b0;
  logic [19:0] env_t;
  always @(posedge clk) begin
    env_t = alu_calc(bus.alu_A, bus.alu_B, bus.alu_op);
    if (force_bad) env_t[18] = 1'b0;
    bus.alu_flags  <= env_t[19:16];
    bus.alu_result <= env_t[15:0];
  end

  function automatic int rr_search(input logic [N-1:0] v, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j[IDW-1:0]]) return j;
    end
    return -1;
  endfunction

  // model state: whole transactions, counted in cycles since the grant
  bit          started = 1'b0;
  bit          m_busy = 1'b0;
  int          m_t = 0, m_ptr = 0, m_g = 0;
  bit          m_bad = 1'b0, m_ferr = 1'b0;
  logic [15:0] m_a = '0, m_b = '0, m_rres = '0;
  logic [1:0]  m_op = '0, m_rid = '0;
  logic [3:0]  m_rflg = '0;
  int          hs_cnt = 0;
  int          resp_q[$];

  // compare DUT to model every cycle, then advance model over the next edge
  always @(negedge clk) begin
    int          g;
    logic [N-1:0] e_rdy;
    bit          e_rv;
    logic [19:0] t;
    if (started) begin
      g = m_busy ? -1 : rr_search(bus.req_valid, m_ptr);
      e_rdy = '0;
      if (g >= 0) e_rdy[g[IDW-1:0]] = 1'b1;
      e_rv = m_busy && (m_t >= LAT + 2);
      chk("req_ready",   bus.req_ready,   e_rdy);
      chk("busy",        bus.busy,        m_busy);
      chk("resp_valid",  bus.resp_valid,  e_rv);
      chk("resp_id",     bus.resp_id,     m_rid);
      chk("resp_result", bus.resp_result, m_rres);
      chk("resp_flags",  bus.resp_flags,  m_rflg);
      chk("alu_A",       bus.alu_A,       m_a);
      chk("alu_B",       bus.alu_B,       m_b);
      chk("alu_op",      bus.alu_op,      m_op);
`ifdef ALU_ARB_FLAG_CHECK_EN
      chk("flag_err",    flag_err,        m_ferr);
`endif
      if (!rst && bus.resp_valid && bus.resp_ready) begin
        hs_cnt++;
        resp_q.push_back(int'(bus.resp_id));
      end
      if (rst) begin
        m_busy = 0; m_t = 0; m_ptr = 0; m_g = 0; m_ferr = 0;
        m_a = '0; m_b = '0; m_op = '0; m_rid = '0; m_rres = '0; m_rflg = '0;
      end else if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1; m_t = 1; m_g = g; m_bad = force_bad;
          m_a  = bus.req_a[g[IDW-1:0]];
          m_b  = bus.req_b[g[IDW-1:0]];
          m_op = bus.req_op[g[IDW-1:0]];
        end
      end else if (e_rv && bus.resp_ready) begin
        m_busy = 0;
        m_ptr  = (m_g + 1) % N;
      end else begin
        m_t++;
        if (m_t == LAT + 2) begin
          t = alu_calc(m_a, m_b, m_op);
          if (m_bad) t[18] = 1'b0;
          m_rid = m_g[IDW-1:0]; m_rres = t[15:0]; m_rflg = t[19:16];
          if (t[18] != (t[15:0] == 16'd0) || t[16] != t[15]) m_ferr = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    bus.req_a[id[IDW-1:0]]     = a;
    bus.req_b[id[IDW-1:0]]     = b;
    bus.req_op[id[IDW-1:0]]    = op;
    bus.req_valid[id[IDW-1:0]] = 1'b1;
  endtask

  task automatic drop(input int id);
    bus.req_valid[id[IDW-1:0]] = 1'b0;
  endtask

  task automatic wait_grant(input int id);
    int t = 0;
    @(negedge clk);
    while (bus.req_ready[id[IDW-1:0]] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin n_cmp++; n_err++; $display("FAIL grant_timeout: requester %0d never granted", id); end
  endtask

  task automatic wait_resp();
    int t = 0;
    @(negedge clk);
    while (bus.resp_valid !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin n_cmp++; n_err++; $display("FAIL resp_timeout: resp_valid never rose"); end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin n_cmp++; n_err++; $display("FAIL idle_timeout: busy stuck high"); end
  endtask

  task automatic chk_resp(input string nm, input int id, input logic [15:0] r, input logic [3:0] f);
    wait_resp();
    chk({nm, "_id"},     bus.resp_id,     id);
    chk({nm, "_result"}, bus.resp_result, r);
    chk({nm, "_flags"},  bus.resp_flags,  f);
  endtask

  initial begin
    int hs0;
    int gq[$];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    started = 1'b1;
    step();
    rst = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_result", bus.resp_result, 0);
    chk("rst_resp_flags", bus.resp_flags, 0);
    chk("rst_alu_A", bus.alu_A, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_ready", bus.req_ready, 0);

    // single request from 0: 3 + 4
    step();
    set_req(0, 16'h0003, 16'h0004, OP_ADD);
    wait_grant(0);
    chk("single_ready", bus.req_ready, 4'b0001);
    step(); drop(0);
    @(negedge clk);
    chk("single_ready_pulse", bus.req_ready, 4'b0000);
    chk_resp("single", 0, 16'h0007, 4'b0000);
    step();

    // all four continuously valid from reset
    rst = 1'b1; step(); rst = 1'b0;
    resp_q.delete();
    for (int i = 0; i < N; i++) set_req(i, 16'(i + 1), 16'h0010, OP_ADD);
    for (int c = 0; c < 200 && gq.size() < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) gq.push_back(i);
    end
    step();
    bus.req_valid = '0;
    wait_idle();
    chk("rr_grant_count", gq.size(), 5);
    chk("rr_resp_count", resp_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < gq.size()) chk("rr_grant_order", gq[i], exp_order[i]);
      if (i < resp_q.size()) chk("rr_resp_order", resp_q[i], exp_order[i]);
    end

    // edge operands from requester 2: 0xFFFF - 1
    step();
    set_req(2, 16'hFFFF, 16'h0001, OP_SUB);
    wait_grant(2);
    step(); drop(2);
    chk_resp("edge", 2, 16'hFFFE, 4'b0001);
    step();

    // backpressure: requester 3 held in RESP for 5 cycles, requester 0 waiting
    bus.resp_ready = 1'b0;
    set_req(3, 16'h1234, 16'h00FF, OP_AND);
    wait_grant(3);
    step(); drop(3);
    set_req(0, 16'h8000, 16'h8000, OP_ADD);
    hs0 = hs_cnt;
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", bus.resp_valid, 1);
      chk("bp_resp_id", bus.resp_id, 3);
      chk("bp_resp_result", bus.resp_result, 16'h0034);
      chk("bp_resp_flags", bus.resp_flags, 4'b0000);
      chk("bp_busy", bus.busy, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      if (i < 4) @(negedge clk);
    end
    step();
    bus.resp_ready = 1'b1;
    wait_grant(0);
    chk("bp_one_resp", hs_cnt - hs0, 1);
    step(); drop(0);
    chk_resp("bp_next", 0, 16'h0000, 4'b1110);
    step();

    // move pointer to 3, then abort requester 1 mid-WAIT with reset
    set_req(2, 16'h0005, 16'h0005, OP_OR);
    wait_grant(2);
    step(); drop(2);
    chk_resp("pre_abort", 2, 16'h0005, 4'b0000);
    step();
    set_req(1, 16'h0100, 16'h0001, OP_ADD);
    wait_grant(1);
    step(); drop(1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("abort_resp_valid", bus.resp_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_alu_A", bus.alu_A, 0);
    chk("abort_alu_B", bus.alu_B, 0);
    chk("abort_resp_result", bus.resp_result, 0);
    step();
    set_req(1, 16'h0100, 16'h0001, OP_ADD);
    set_req(3, 16'h0F0F, 16'h00F0, OP_OR);
    @(negedge clk);
    chk("abort_ptr_reset", bus.req_ready, 4'b0010);
    step(); drop(1);
    chk_resp("after_abort", 1, 16'h0101, 4'b0000);
    step();
    wait_grant(3);
    step(); drop(3);
    chk_resp("after_abort_3", 3, 16'h0FFF, 4'b0000);
    step();

`ifdef ALU_ARB_FLAG_CHECK_EN
    // inconsistent zero flag sets the sticky error
    force_bad = 1'b1;
    set_req(0, 16'h0000, 16'h0000, OP_ADD);
    wait_grant(0);
    step(); drop(0);
    chk_resp("ferr", 0, 16'h0000, 4'b0000);
    chk("ferr_set", flag_err, 1);
    step();
    force_bad = 1'b0;
    set_req(1, 16'h0001, 16'h0001, OP_AND);
    wait_grant(1);
    step(); drop(1);
    chk_resp("ferr_good", 1, 16'h0001, 4'b0000);
    chk("ferr_sticky", flag_err, 1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("ferr_cleared", flag_err, 0);
`endif

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
